// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision FPU slice.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_NORM,
    S_DONE
  } state_t;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  // Extended mantissa: binary point sits below bit MANT_W-2, bit MANT_W-1 catches carry.
  localparam int MANT_W = 50;

  typedef logic signed [11:0] exp_t;

  function automatic logic [5:0] lzc(input logic [MANT_W-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int unsigned i = 0; i < MANT_W; i++) begin
      if (v[i]) n = 6'(MANT_W - 1 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fpu_if.sv
// Request/result bundle between a controller and fpu_core.
interface fpu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  Sel;
  logic        round;
  logic        start;
  logic        Error;
  logic        Overflow;
  logic        Underflow;
  logic        done;
  logic [31:0] Y;

  modport master (output A, B, Sel, round, start,
                  input  Error, Overflow, Underflow, done, Y);
  modport slave  (input  A, B, Sel, round, start,
                  output Error, Overflow, Underflow, done, Y);
endinterface

// File: rtl/fpu_norm_round.sv
// Normalise an extended mantissa, round it and pack the IEEE single result.
module fpu_norm_round
  import fpu_pkg::*;
(
  input  logic              sign,
  input  exp_t              exp,
  input  logic [MANT_W-1:0] mant,
  input  logic              sticky,
  input  logic              round,
  output logic [31:0]       y,
  output logic              overflow,
  output logic              underflow
);

  logic [5:0]        lz;
  logic [MANT_W-1:0] mn;
  exp_t              en;
  exp_t              ef;
  logic              g, r, s, inc;
  logic [24:0]       m25;
  logic [22:0]       mf;

  always_comb begin
    lz  = lzc(mant);
    // After the shift the leading one sits in the top bit; +1 rebases the exponent.
    mn  = mant << lz;
    en  = exp + exp_t'(1) - exp_t'({6'b0, lz});
    g   = mn[25];
    r   = mn[24];
    s   = (|mn[23:0]) | sticky;
    inc = round & g & (r | s | mn[26]);
    m25 = {1'b0, mn[49:26]} + 25'(inc);
    if (m25[24]) begin
      mf = m25[23:1];
      ef = en + exp_t'(1);
    end else begin
      mf = m25[22:0];
      ef = en;
    end

    y         = {sign, 31'b0};
    overflow  = 1'b0;
    underflow = 1'b0;
    if (mant != '0) begin
      if (ef > exp_t'(EXP_MAX - 1)) begin
        y        = {sign, POS_INF[30:0]};
        overflow = 1'b1;
      end else if (ef < exp_t'(1)) begin
        underflow = 1'b1;
      end else begin
        y = {sign, ef[7:0], mf};
      end
    end
  end

endmodule

// File: rtl/fpu_core.sv
// Multi-cycle single-precision add/sub/mul/div with start/done handshake.
// Define FPU_DIV_EN to build the divider; otherwise Sel=11 reports Error.
module fpu_core
  import fpu_pkg::*;
#(
  parameter int unsigned LATENCY = 3
) (
  input logic  Clock,
  input logic  Reset,
  fpu_if.slave bus
);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] a_q, b_q;
  op_t         op_q;
  logic        rnd_q;

  logic              r_sign, r_sticky, r_err;
  exp_t              r_exp;
  logic [MANT_W-1:0] r_mant;

  logic [31:0] y_q;
  logic        err_q, ovf_q, unf_q, done_q;

  logic              sa, sb, sb_e, za, zb, xa, xb;
  logic [7:0]        ea, eb, le, se, dsh;
  logic [23:0]       ma, mb, lm, sm;
  logic [30:0]       mag_a, mag_b;
  logic              a_ge, lsign, st;
  logic [46:0]       al;
  logic [48:0]       sum;
  logic [47:0]       prod;
  logic              c_sign, c_sticky, c_err;
  exp_t              c_exp;
  logic [MANT_W-1:0] c_mant;
`ifdef FPU_DIV_EN
  logic [49:0]       num, den;
  logic [26:0]       quo;
  logic [23:0]       rem;
`endif

  logic [31:0] n_y;
  logic        n_ovf, n_unf;

  always_comb begin
    sa    = a_q[31];
    sb    = b_q[31];
    ea    = a_q[30:23];
    eb    = b_q[30:23];
    za    = (ea == '0);
    zb    = (eb == '0);
    xa    = (ea == 8'(EXP_MAX));
    xb    = (eb == 8'(EXP_MAX));
    ma    = za ? '0 : {1'b1, a_q[22:0]};
    mb    = zb ? '0 : {1'b1, b_q[22:0]};
    sb_e  = (op_q == OP_SUB) ? ~sb : sb;
    mag_a = {ea, ma[22:0]};
    mag_b = {eb, mb[22:0]};
    a_ge  = (mag_a >= mag_b);
    lsign = a_ge ? sa : sb_e;
    le    = a_ge ? ea : eb;
    se    = a_ge ? eb : ea;
    lm    = a_ge ? ma : mb;
    sm    = a_ge ? mb : ma;
    dsh   = le - se;
    // Bits shifted past the bottom collapse into one sticky LSB so subtraction borrows correctly.
    al    = {sm, 23'b0} >> dsh;
    st    = |({sm, 23'b0} & ~({47{1'b1}} << dsh));
    sum   = (sa ^ sb_e) ? ({1'b0, lm, 23'b0, 1'b0} - {1'b0, al, st})
                        : ({1'b0, lm, 23'b0, 1'b0} + {1'b0, al, st});
    prod  = ma * mb;
`ifdef FPU_DIV_EN
    num   = {ma, 26'b0};
    den   = zb ? 50'd1 : {26'b0, mb};
    quo   = 27'(num / den);
    rem   = 24'(num % den);
`endif

    c_sign   = 1'b0;
    c_exp    = '0;
    c_mant   = '0;
    c_sticky = 1'b0;
    c_err    = xa | xb;
    case (op_q)
      OP_ADD, OP_SUB: begin
        c_sign = (sum == '0) ? 1'b0 : lsign;
        c_exp  = exp_t'({4'b0, le});
        c_mant = {sum, 1'b0};
      end
      OP_MUL: begin
        c_sign = sa ^ sb;
        c_exp  = exp_t'({4'b0, ea}) + exp_t'({4'b0, eb}) - exp_t'(BIAS);
        c_mant = {prod, 2'b0};
      end
      OP_DIV: begin
`ifdef FPU_DIV_EN
        c_err    = xa | xb | zb;
        c_sign   = sa ^ sb;
        c_exp    = exp_t'({4'b0, ea}) - exp_t'({4'b0, eb}) + exp_t'(BIAS);
        c_mant   = {1'b0, quo, 22'b0};
        c_sticky = (rem != '0);
`else
        c_err = 1'b1;
`endif
      end
    endcase
  end

  fpu_norm_round u_norm (
    .sign      (r_sign),
    .exp       (r_exp),
    .mant      (r_mant),
    .sticky    (r_sticky),
    .round     (rnd_q),
    .y         (n_y),
    .overflow  (n_ovf),
    .underflow (n_unf)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      rnd_q    <= 1'b0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_sticky <= 1'b0;
      r_err    <= 1'b0;
      y_q      <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            op_q  <= op_t'(bus.Sel);
            rnd_q <= bus.round;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_sign   <= c_sign;
          r_exp    <= c_exp;
          r_mant   <= c_mant;
          r_sticky <= c_sticky;
          r_err    <= c_err;
          cnt      <= '0;
          state    <= S_NORM;
        end
        S_NORM: begin
          if (cnt == 4'(LATENCY - 2)) begin
            y_q    <= r_err ? QNAN : n_y;
            err_q  <= r_err;
            ovf_q  <= r_err ? 1'b0 : n_ovf;
            unf_q  <= r_err ? 1'b0 : n_unf;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Y         = y_q;
  assign bus.Error     = err_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = unf_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fpu_core.sv
// Directed self-checking bench for fpu_core (LATENCY=3).
module tb_fpu_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat;
  int   pulses;

  fpu_if bus ();

  fpu_core #(.LATENCY(3)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for done; optionally poke start while busy.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                     input logic r, input logic poke);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.Sel = s; bus.round = r; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (poke && lat == 1) begin
        bus.A = '0; bus.B = '0; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
  endtask

  task automatic result(input string tag, input logic [31:0] y, input logic [2:0] fl);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_y"}, bus.Y, y);
    chk({tag, "_flags"}, {29'b0, bus.Error, bus.Overflow, bus.Underflow}, {29'b0, fl});
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    bus.A = '0; bus.B = '0; bus.Sel = '0; bus.round = 1'b0; bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", bus.Y, 32'h0);
    chk("rst_flags", {28'b0, bus.Error, bus.Overflow, bus.Underflow, bus.done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run(32'h4370_0000, 32'h42F0_0000, 2'b00, 1'b0, 1'b1);
    result("add", 32'h43B4_0000, 3'b000);
    repeat (4) @(posedge clk);
    #1;
    chk("add_hold", bus.Y, 32'h43B4_0000);

    run(32'h4350_0000, 32'h42B0_0000, 2'b01, 1'b0, 1'b0);
    result("sub", 32'h42F0_0000, 3'b000);
    run(32'h42F0_0000, 32'h4370_0000, 2'b01, 1'b0, 1'b0);
    result("sub_neg", 32'hC2F0_0000, 3'b000);
    run(32'h7F01_0000, 32'h7F01_0000, 2'b01, 1'b0, 1'b0);
    result("sub_zero", 32'h0000_0000, 3'b000);

    run(32'hC370_0000, 32'hC2F0_0000, 2'b10, 1'b0, 1'b0);
    result("mul", 32'h46E1_0000, 3'b000);
    run(32'h8000_0000, 32'h4000_0000, 2'b10, 1'b0, 1'b0);
    result("mul_zero", 32'h8000_0000, 3'b000);
    run(32'h8D80_0000, 32'h0D80_0000, 2'b10, 1'b0, 1'b0);
    result("mul_unf", 32'h8000_0000, 3'b001);

    run(32'h4370_0000, 32'hC2F0_0000, 2'b11, 1'b0, 1'b0);
`ifdef FPU_DIV_EN
    result("div", 32'hC000_0000, 3'b000);
`else
    result("div_off", 32'h7FC0_0000, 3'b100);
`endif

    run(32'h7F01_0000, 32'h7F01_0000, 2'b00, 1'b0, 1'b0);
    result("ovf", 32'h7F80_0000, 3'b010);

    run(32'h7F80_0000, 32'hFF80_0000, 2'b00, 1'b0, 1'b0);
    result("err_inf", 32'h7FC0_0000, 3'b100);
    run(32'h0000_0000, 32'h7F80_0000, 2'b10, 1'b0, 1'b0);
    result("err_0xinf", 32'h7FC0_0000, 3'b100);
    run(32'h0000_0000, 32'h0000_0000, 2'b11, 1'b0, 1'b0);
    result("err_0div0", 32'h7FC0_0000, 3'b100);

    run(32'h4000_8000, 32'h4080_8000, 2'b00, 1'b0, 1'b0);
    result("rnd_t", 32'h40C0_C000, 3'b000);
    run(32'h4000_8000, 32'h4080_8000, 2'b00, 1'b1, 1'b0);
    result("rnd_n", 32'h40C0_C000, 3'b000);
    run(32'h3F80_0000, 32'h33C0_0000, 2'b00, 1'b0, 1'b0);
    result("gr_trunc", 32'h3F80_0000, 3'b000);
    run(32'h3F80_0000, 32'h33C0_0000, 2'b00, 1'b1, 1'b0);
    result("gr_near", 32'h3F80_0001, 3'b000);
    run(32'h3F80_0000, 32'h3380_0000, 2'b00, 1'b1, 1'b0);
    result("tie_even", 32'h3F80_0000, 3'b000);
    run(32'h3F80_0001, 32'h3380_0000, 2'b00, 1'b1, 1'b0);
    result("tie_odd", 32'h3F80_0002, 3'b000);

    // Abort an operation in flight with an asynchronous reset.
    @(negedge clk);
    bus.A = 32'h4370_0000; bus.B = 32'h42F0_0000; bus.Sel = 2'b00; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_y", bus.Y, 32'h0);
    chk("abort_flags", {28'b0, bus.Error, bus.Overflow, bus.Underflow, bus.done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    chk("abort_nodone", 32'(pulses), 32'd0);

    run(32'h4370_0000, 32'h42F0_0000, 2'b00, 1'b0, 1'b0);
    result("recover", 32'h43B4_0000, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_core.md
Name: fpu_core

Overview:
- Multi-cycle IEEE-754 single-precision floating-point unit with start/done handshake.
- Operations: add, subtract, multiply and divide on two 32-bit operands.
- Selectable rounding: truncate, or round-to-nearest-even.
- Status flags: Error, Overflow, Underflow.
- Standalone arithmetic block driven by a controller that pulses start and waits for done.

Parameters:
- LATENCY, 3, clock cycles from the start-sampling edge to the done pulse; must be 2..10.

Ports:
- Clock  input  1  single system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- A  input  32  operand A (sign[31], exp[30:23], frac[22:0])
- B  input  32  operand B
- Sel  input  2  00 = A+B, 01 = A−B, 10 = A×B, 11 = A÷B
- round  input  1  0 = truncate toward zero; 1 = round-to-nearest, ties-to-even
- start  input  1  one-cycle request pulse
- Error  output  1  invalid operation
- Overflow  output  1  result exponent exceeds 254
- Underflow  output  1  nonzero result exponent below 1
- done  output  1  one-cycle result-valid pulse
- Y  output  32  result

Behaviour:
- Reset (asynchronous): FSM goes to IDLE; Y=0, done=0, Error=0, Overflow=0, Underflow=0. Reset mid-operation aborts the operation with no done pulse.
- FSM states:
  - IDLE: sample start=1; register A, B, Sel, round; go to EXEC.
  - EXEC: compute raw sign, exponent and extended mantissa (guard, round, sticky bits).
  - NORM: normalize, round, check exceptions. Remain in EXEC/NORM until LATENCY−1 cycles have elapsed.
  - DONE: update Y and flags; assert done for exactly one cycle; return to IDLE.
- start while not in IDLE is ignored.
- Y and flags hold their values until the next operation completes.
- Operands with exp=0 (zero or subnormal) are treated as signed zero (flush-to-zero). Subnormal results are never produced.
- Error rules (Error=1 forces Y=0x7FC00000, Overflow=0, Underflow=0):
  - any operand with exp=255 (Inf or NaN);
  - 0×anything-zero-valued invalid combination, i.e. 0÷0;
  - division of nonzero by zero.
- Add/sub:
  - Sub negates B's sign.
  - Align the smaller exponent; the shifted-out bits feed guard/round/sticky.
  - Add or subtract magnitudes; result sign is the sign of the larger magnitude.
  - Exact-zero result gives Y=0x00000000.
- Multiply:
  - 24×24 mantissa product; exponent = eA+eB−127; sign = sA XOR sB.
  - A zero operand gives a signed zero.
- Divide:
  - (mA<<26)/mB quotient; a nonzero remainder sets sticky.
  - Exponent = eA−eB+127; sign XOR.
  - Zero dividend gives signed zero (0x00000000 or 0x80000000).
- Rounding:
  - Truncate discards extra bits.
  - Nearest-even increments when G&(R|S|LSB).
  - A carry out of the mantissa renormalizes and increments the exponent.
- Overflow: final exponent > 254 → Y=sign|0x7F800000, Overflow=1.
- Underflow: final exponent < 1 with nonzero mantissa → Y=signed zero, Underflow=1.

Optional Feature:
- Macro FPU_DIV_EN.
- Defined: Sel=11 performs division as specified above.
- Undefined: the divider is omitted; Sel=11 completes with the normal latency, Error=1, Y=0x7FC00000.

Decomposition:
- Package fpu_pkg holds:
  - op encodings OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - BIAS=127, EXP_MAX=255;
  - QNAN=0x7FC00000, POS_INF=0x7F800000;
  - FSM state enum.
- One sub-module, fpu_norm_round: takes sign, exponent and extended mantissa plus round; produces packed result, Overflow and Underflow.

Test Plan:
- Sel=00, A=0x43700000 (240), B=0x42F00000 (120) → done 3 cycles after start; Y=0x43B40000, all flags 0.
- Sel=01, A=0x43500000, B=0x42B00000 → Y=0x42F00000. Same operands with Sel=01 on A=B=0x7F010000 → Y=0x00000000.
- Sel=10, A=0xC3700000, B=0xC2F00000 → Y=0x46E10000. Sel=11, A=0x43700000, B=0xC2F00000 → Y=0xC0000000.
- Sel=00, A=B=0x7F010000 → Overflow=1, Y=0x7F800000.
- Error cases, each → Error=1, Y=0x7FC00000:
  - Sel=00, A=0x7F800000, B=0xFF800000;
  - Sel=10, A=0, B=0x7F800000;
  - Sel=11, A=B=0.
- Sel=00, A=0x40008000, B=0x40808000, round=0 and round=1 → Y=0x40C0C000 both times. Reset asserted mid-operation → no done pulse, outputs return to 0.
